// File: rtl/obj_queue_ctrl.sv
// obj_queue_ctrl: circular queue of track objects; retires passed objects into hit events
// and streams an ordered snapshot of live entries to the renderer.
module obj_queue_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [15:0]            wr_obj_i,
    input  logic [11:0]            player_dist_i,
    input  logic [1:0]             player_lane_i,
    input  logic                   scan_start_i,
    output logic                   scan_valid_o,
    output logic [15:0]            scan_obj_o,
    output logic                   scan_last_o,
    output logic                   scan_done_o,
    output logic                   coin_hit_o,
    output logic                   wall_hit_o,
    output logic                   turn_evt_o,
    output logic [1:0]             turn_dir_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q;
    logic [15:0]     mem_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q, scan_idx_q;
    logic [CW-1:0]   count_q, scan_rem_q;
    logic            full_q, empty_q, drop_q;
    logic            scan_valid_q, scan_last_q, scan_done_q;
    logic [15:0]     scan_obj_q;
    logic            coin_hit_q, wall_hit_q, turn_evt_q;
    logic [1:0]      turn_dir_q;

    logic [15:0]     head_obj;
    logic [1:0]      head_type;
    logic [11:0]     gap;
    logic            pop, accept, lane_hit;
    logic [CW-1:0]   count_d, snap_n;
    logic [PW-1:0]   head_d, tail_d;

    // The gap wraps mod 2^12, so its sign bit alone says the player is past the head object.
    always_comb begin
        head_obj  = mem_q[head_q];
        head_type = head_obj[13:12];
        gap       = head_obj[11:0] - player_dist_i;
        pop       = (state_q == IDLE) && (count_q != '0) && gap[11];
        accept    = push_i && ((count_q != CW'(DEPTH)) || pop);
        lane_hit  = head_obj[15:14] == player_lane_i;
        count_d   = count_q + CW'(accept) - CW'(pop);
        head_d    = head_q + PW'(pop);
        tail_d    = tail_q + PW'(accept);
        snap_n    = count_q - CW'(pop);
    end

    // A scan requested in the same cycle as a pop covers only the entries that survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            scan_idx_q   <= '0;
            count_q      <= '0;
            scan_rem_q   <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            drop_q       <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_obj_q   <= '0;
            coin_hit_q   <= 1'b0;
            wall_hit_q   <= 1'b0;
            turn_evt_q   <= 1'b0;
            turn_dir_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            full_q       <= count_d == CW'(DEPTH);
            empty_q      <= count_d == '0;
            drop_q       <= push_i && !accept;
            if (accept) mem_q[tail_q] <= wr_obj_i;
            coin_hit_q   <= pop && head_type == 2'b00 && lane_hit;
            wall_hit_q   <= pop && head_type == 2'b10 && lane_hit;
            turn_evt_q   <= pop && head_type == 2'b01;
            if (pop && head_type == 2'b01) turn_dir_q <= head_obj[15:14];
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_obj_q   <= '0;
            if (state_q == IDLE) begin
                if (scan_start_i) begin
                    if (snap_n == '0) begin
                        scan_done_q <= 1'b1;
                    end else begin
                        state_q    <= SCAN;
                        scan_idx_q <= head_d;
                        scan_rem_q <= snap_n;
                    end
                end
            end else begin
                scan_valid_q <= 1'b1;
                scan_obj_q   <= mem_q[scan_idx_q];
                scan_idx_q   <= scan_idx_q + 1'b1;
                scan_rem_q   <= scan_rem_q - 1'b1;
                if (scan_rem_q == CW'(1)) begin
                    scan_last_q <= 1'b1;
                    scan_done_q <= 1'b1;
                    state_q     <= IDLE;
                end
            end
        end
    end

    assign scan_valid_o = scan_valid_q;
    assign scan_obj_o   = scan_obj_q;
    assign scan_last_o  = scan_last_q;
    assign scan_done_o  = scan_done_q;
    assign coin_hit_o   = coin_hit_q;
    assign wall_hit_o   = wall_hit_q;
    assign turn_evt_o   = turn_evt_q;
    assign turn_dir_o   = turn_dir_q;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign drop_o       = drop_q;
endmodule

// File: tb/tb_obj_queue_ctrl.sv
// tb_obj_queue_ctrl: scoreboard bench for obj_queue_ctrl; expected scan entries and hit
// events are queued as stimulus is driven and popped as the DUT produces them.
module tb_obj_queue_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic        scan_start = 1'b0;
    logic [15:0] wr_obj = '0;
    logic [11:0] player_dist = '0;
    logic [1:0]  player_lane = '0;
    logic        scan_valid, scan_last, scan_done;
    logic [15:0] scan_obj;
    logic        coin_hit, wall_hit, turn_evt;
    logic [1:0]  turn_dir;
    logic [3:0]  count;
    logic        full, empty, drop;

    int tests = 0;
    int fails = 0;
    logic [15:0] model[$];
    logic [15:0] exp_scan[$];
    logic [4:0]  exp_evt[$];

    obj_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push_i(push), .wr_obj_i(wr_obj),
        .player_dist_i(player_dist), .player_lane_i(player_lane), .scan_start_i(scan_start),
        .scan_valid_o(scan_valid), .scan_obj_o(scan_obj), .scan_last_o(scan_last),
        .scan_done_o(scan_done), .coin_hit_o(coin_hit), .wall_hit_o(wall_hit),
        .turn_evt_o(turn_evt), .turn_dir_o(turn_dir), .count_o(count),
        .full_o(full), .empty_o(empty), .drop_o(drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; push = 1'b0; scan_start = 1'b0; wr_obj = '0;
        player_dist = '0; player_lane = '0;
        #7;
        rst_n = 1'b1;
        model.delete(); exp_scan.delete(); exp_evt.delete();
        step();
    endtask

    task automatic do_push(input logic [15:0] o);
        push = 1'b1; wr_obj = o;
        step();
        push = 1'b0;
        model.push_back(o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++; $display("FAIL reset_level: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
        end
        tests++;
        if (scan_valid !== 1'b0 || scan_last !== 1'b0 || scan_done !== 1'b0 || scan_obj !== 16'h0) begin
            fails++; $display("FAIL reset_scan: valid=%b last=%b done=%b obj=%h, want all 0", scan_valid, scan_last, scan_done, scan_obj);
        end
        tests++;
        if (coin_hit !== 1'b0 || wall_hit !== 1'b0 || turn_evt !== 1'b0 || drop !== 1'b0 || turn_dir !== 2'b00) begin
            fails++; $display("FAIL reset_pulse: c=%b w=%b t=%b drop=%b dir=%b, want 0", coin_hit, wall_hit, turn_evt, drop, turn_dir);
        end
    endtask

    task automatic test_coin_hit();
        logic [4:0] e;
        do_reset();
        player_lane = 2'b00; player_dist = 12'd99;
        do_push({2'b00, 2'b00, 12'd100});
        tests++;
        if (count !== 1 || empty !== 1'b0) begin
            fails++; $display("FAIL coin_push: count=%0d empty=%b, want 1/0", count, empty);
        end
        step();
        player_dist = 12'd100;
        step();
        tests++;
        if (count !== 1 || coin_hit !== 1'b0) begin
            fails++; $display("FAIL coin_early: count=%0d coin=%b, want 1/0", count, coin_hit);
        end
        step();
        tests++;
        if (count !== 1) begin
            fails++; $display("FAIL coin_gap_zero: count=%0d, want 1", count);
        end
        player_dist = 12'd101;
        exp_evt.push_back({3'b100, 2'b00});
        step();
        tests++;
        if (count !== 0 || empty !== 1'b1) begin
            fails++; $display("FAIL coin_retire: count=%0d empty=%b, want 0/1", count, empty);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            if (coin_hit || wall_hit || turn_evt) begin
                tests++;
                if (exp_evt.size() == 0) begin
                    fails++; $display("FAIL coin_evt: unexpected c/w/t=%b%b%b", coin_hit, wall_hit, turn_evt);
                end else begin
                    e = exp_evt.pop_front();
                    if ({coin_hit, wall_hit, turn_evt} !== e[4:2]) begin
                        fails++; $display("FAIL coin_evt: c/w/t=%b%b%b, want %b", coin_hit, wall_hit, turn_evt, e[4:2]);
                    end
                end
            end
        end
        tests++;
        if (exp_evt.size() != 0) begin
            fails++; $display("FAIL coin_missed: %0d events outstanding, want 0", exp_evt.size());
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        player_lane = 2'b01;
        for (int i = 0; i < DEPTH; i++) do_push({2'b00, 2'b00, 12'd500});
        tests++;
        if (count !== 8 || full !== 1'b1 || drop !== 1'b0) begin
            fails++; $display("FAIL fill: count=%0d full=%b drop=%b, want 8/1/0", count, full, drop);
        end
        push = 1'b1; wr_obj = {2'b00, 2'b00, 12'd501};
        step();
        push = 1'b0;
        tests++;
        if (drop !== 1'b1 || count !== 8) begin
            fails++; $display("FAIL drop: drop=%b count=%0d, want 1/8", drop, count);
        end
        step();
        tests++;
        if (drop !== 1'b0) begin
            fails++; $display("FAIL drop_pulse: drop=%b, want 0", drop);
        end
        player_dist = 12'd501; push = 1'b1; wr_obj = {2'b00, 2'b00, 12'd502};
        step();
        push = 1'b0; player_dist = 12'd0;
        tests++;
        if (drop !== 1'b0 || count !== 8 || full !== 1'b1) begin
            fails++; $display("FAIL push_pop_full: drop=%b count=%0d full=%b, want 0/8/1", drop, count, full);
        end
        step();
        tests++;
        if (count !== 8) begin
            fails++; $display("FAIL push_pop_hold: count=%0d, want 8", count);
        end
    endtask

    task automatic test_scan_order();
        logic [15:0] e;
        logic [4:0]  ev;
        bit done = 1'b0;
        int first = -1;
        do_reset();
        player_lane = 2'b10;
        do_push({2'b10, 2'b00, 12'd300});
        do_push({2'b01, 2'b10, 12'd301});
        do_push({2'b00, 2'b01, 12'd302});
        exp_scan = model;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        tests++;
        if (scan_valid !== 1'b0 || count !== 3) begin
            fails++; $display("FAIL scan_start: valid=%b count=%0d, want 0/3", scan_valid, count);
        end
        player_dist = 12'd400; push = 1'b1; wr_obj = {2'b00, 2'b00, 12'd350};
        for (int k = 0; k < 6 && !done; k++) begin
            step();
            push = 1'b0;
            if (scan_valid) begin
                if (first < 0) first = k;
                tests++;
                if (exp_scan.size() == 0) begin
                    fails++; $display("FAIL scan_entry: unexpected obj=%h", scan_obj);
                end else begin
                    e = exp_scan.pop_front();
                    if (scan_obj !== e || scan_last !== (exp_scan.size() == 0)) begin
                        fails++; $display("FAIL scan_entry: obj=%h last=%b, want %h/%b", scan_obj, scan_last, e, exp_scan.size() == 0);
                    end
                end
            end
            if (scan_done) begin
                done = 1'b1;
                tests++;
                if (scan_last !== 1'b1 || exp_scan.size() != 0 || count !== 4) begin
                    fails++; $display("FAIL scan_end: last=%b left=%0d count=%0d, want 1/0/4", scan_last, exp_scan.size(), count);
                end
            end
        end
        tests++;
        if (!done || first != 0) begin
            fails++; $display("FAIL scan_timing: done=%b first=%0d, want 1/0", done, first);
        end
        exp_evt.push_back({3'b100, 2'b00});
        exp_evt.push_back({3'b001, 2'b00});
        for (int k = 0; k < 8; k++) begin
            step();
            if (coin_hit || wall_hit || turn_evt) begin
                tests++;
                if (exp_evt.size() == 0) begin
                    fails++; $display("FAIL scan_retire_evt: unexpected c/w/t=%b%b%b", coin_hit, wall_hit, turn_evt);
                end else begin
                    ev = exp_evt.pop_front();
                    if ({coin_hit, wall_hit, turn_evt} !== ev[4:2] || (ev[2] && turn_dir !== ev[1:0])) begin
                        fails++; $display("FAIL scan_retire_evt: c/w/t=%b%b%b dir=%b, want %b/%b", coin_hit, wall_hit, turn_evt, turn_dir, ev[4:2], ev[1:0]);
                    end
                end
            end
        end
        tests++;
        if (count !== 0 || empty !== 1'b1 || exp_evt.size() != 0) begin
            fails++; $display("FAIL scan_drain: count=%0d empty=%b left=%0d, want 0/1/0", count, empty, exp_evt.size());
        end
    endtask

    task automatic test_empty_scan();
        do_reset();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        tests++;
        if (scan_done !== 1'b1 || scan_valid !== 1'b0) begin
            fails++; $display("FAIL empty_scan: done=%b valid=%b, want 1/0", scan_done, scan_valid);
        end
        step();
        tests++;
        if (scan_done !== 1'b0 || scan_valid !== 1'b0) begin
            fails++; $display("FAIL empty_scan_after: done=%b valid=%b, want 0/0", scan_done, scan_valid);
        end
    endtask

    task automatic test_wall_turn();
        logic [4:0] ev;
        do_reset();
        player_lane = 2'b01;
        do_push({2'b10, 2'b10, 12'd10});
        do_push({2'b10, 2'b01, 12'd11});
        do_push({2'b01, 2'b10, 12'd12});
        exp_evt.push_back({3'b001, 2'b10});
        exp_evt.push_back({3'b010, 2'b00});
        player_dist = 12'd20;
        for (int k = 0; k < 6; k++) begin
            step();
            if (coin_hit || wall_hit || turn_evt) begin
                tests++;
                if (exp_evt.size() == 0) begin
                    fails++; $display("FAIL wall_turn_evt: unexpected c/w/t=%b%b%b", coin_hit, wall_hit, turn_evt);
                end else begin
                    ev = exp_evt.pop_front();
                    if ({coin_hit, wall_hit, turn_evt} !== ev[4:2] || (ev[2] && turn_dir !== ev[1:0])) begin
                        fails++; $display("FAIL wall_turn_evt: c/w/t=%b%b%b dir=%b, want %b/%b", coin_hit, wall_hit, turn_evt, turn_dir, ev[4:2], ev[1:0]);
                    end
                end
            end
        end
        tests++;
        if (count !== 0 || turn_dir !== 2'b10 || exp_evt.size() != 0) begin
            fails++; $display("FAIL wall_turn_end: count=%0d dir=%b left=%0d, want 0/10/0", count, turn_dir, exp_evt.size());
        end
    endtask

    task automatic test_wrap();
        logic [11:0] steps [4];
        steps = '{12'hFFF, 12'h000, 12'h001, 12'h002};
        do_reset();
        player_lane = 2'b01; player_dist = 12'hFFE;
        do_push({2'b00, 2'b00, 12'h002});
        step(); step();
        tests++;
        if (count !== 1) begin
            fails++; $display("FAIL wrap_hold: count=%0d, want 1", count);
        end
        for (int i = 0; i < 4; i++) begin
            player_dist = steps[i];
            step();
            tests++;
            if (count !== 1) begin
                fails++; $display("FAIL wrap_step: pd=%h count=%0d, want 1", steps[i], count);
            end
        end
        player_dist = 12'h003;
        step();
        tests++;
        if (count !== 0 || empty !== 1'b1) begin
            fails++; $display("FAIL wrap_retire: count=%0d empty=%b, want 0/1", count, empty);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit bad = 1'b0;
        do_reset();
        do_push({2'b00, 2'b00, 12'd200});
        do_push({2'b01, 2'b00, 12'd201});
        do_push({2'b10, 2'b00, 12'd202});
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step();
        tests++;
        if (scan_valid !== 1'b1 || scan_obj !== 16'h00C8) begin
            fails++; $display("FAIL mid_scan_pre: valid=%b obj=%h, want 1/00c8", scan_valid, scan_obj);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (scan_valid !== 1'b0 || scan_obj !== 16'h0 || scan_last !== 1'b0 || scan_done !== 1'b0) begin
            fails++; $display("FAIL async_reset_scan: valid=%b obj=%h last=%b done=%b, want 0", scan_valid, scan_obj, scan_last, scan_done);
        end
        tests++;
        if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            fails++; $display("FAIL async_reset_q: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
        end
        #10;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (scan_done !== 1'b0 || scan_valid !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL abandoned_scan: scan activity after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_coin_hit();
        test_full_drop();
        test_scan_order();
        test_empty_scan();
        test_wall_turn();
        test_wrap();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/obj_queue_ctrl.md
# obj_queue_ctrl

Sequencing controller for the object stream produced by the object generator. Holds upcoming track objects (coins, turns, walls) in a circular queue and retires each one once the player has run past it. At retirement it compares the object against the player's lane and emits hit events to game logic. It also serves a per-frame ordered scan of the live objects to the renderer, and retirement is frozen during a scan so indices stay stable.

## Interface
- DEPTH, 8: queue entries; power of two, 4–16.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- push  in  1  one-cycle write strobe from the object generator.
- wr_obj  in  16  object: [15:14] lane (10 LEFT, 00 MID, 01 RIGHT), [13:12] type (00 COIN, 01 TURN, 10 WALL), [11:0] track distance.
- player_dist  in  12  signed player track distance; advances by at most 1 per cycle.
- player_lane  in  2  current player lane, same encoding as wr_obj[15:14].
- scan_start  in  1  renderer request for a scan; single-cycle pulse.
- scan_valid  out  1  scan_obj holds a queue entry.
- scan_obj  out  16  streamed entry, oldest first.
- scan_last  out  1  with scan_valid: final entry of this scan.
- scan_done  out  1  one-cycle pulse when a scan ends, including an empty scan.
- coin_hit  out  1  pulse: a retired COIN was in the player's lane.
- wall_hit  out  1  pulse: a retired WALL was in the player's lane.
- turn_evt  out  1  pulse: a TURN retired; the direction is on turn_dir.
- turn_dir  out  2  lane field of the retired TURN, held until the next turn_evt.
- count  out  $clog2(DEPTH)+1  live entries.
- full / empty  out  1  count==DEPTH / count==0.
- drop  out  1  pulse: a push was rejected.

## Operation
- Storage: DEPTH×16 registers, head/tail pointers wrapping modulo DEPTH, explicit count.
- Gap: d = head.dist − player_dist, computed mod 2^12 and read as 12-bit signed.
- Retire condition:
  - Requires state IDLE, !empty, and d < 0 (the player has passed the object).
  - At most one pop per cycle.
- Retire classification:
  - COIN with lane==player_lane → coin_hit.
  - WALL with lane==player_lane → wall_hit.
  - TURN in any lane → turn_evt, and turn_dir is loaded from the lane field.
  - Type 11 is reserved: the entry is popped silently.
- Push acceptance:
  - A push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is ignored and drop pulses.
  - A simultaneous accepted push and pop leaves count unchanged.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - Retirement is active.
  - scan_start moves to SCAN and snapshots n=count and the start index = head.
  - If n==0, the block stays in IDLE and pulses scan_done.
- SCAN:
  - Emits entry (start+k) mod DEPTH for k=0..n−1, one per cycle, with scan_valid=1.
  - scan_last is asserted when k=n−1; the block then returns to IDLE and pulses scan_done in the same cycle as scan_last.
  - Pushes are still accepted during SCAN, but they are not in the snapshot.
  - No retirement happens in SCAN.
  - scan_start while in SCAN is ignored.
- Reset, and any asynchronous assertion mid-operation:
  - State IDLE, pointers 0, count 0, empty=1, full=0.
  - All pulses 0, scan_valid/scan_last 0, scan_obj 0, turn_dir 00.
  - An in-progress scan is abandoned without scan_done.

## Timing
- All outputs are registered.
- The retire decision is sampled at edge T from the head entry and the current player_dist/player_lane. The hit pulse and the count update are visible after edge T, one cycle after the condition holds.
- A push at edge T:
  - The entry is stored, and count/full/empty update after edge T.
  - The new entry is retirement-eligible from edge T+1.
- Scan sequence:
  - scan_start sampled at edge T: the first scan_valid is visible after T+1.
  - Entry k is visible after T+1+k.
  - scan_last and scan_done are visible after T+n.
  - Retirement can resume at edge T+n+1.
- If several entries are overdue, they retire on consecutive cycles, head first.
- Distance wrap-around: because d uses mod-2^12 arithmetic, a player_dist of 0xFFE against an object distance of 0x002 gives d=+4, so the object is not retired.

## Test plan
- Retirement and coin hit:
  - Stimulus: reset, push COIN/MID dist 100, player_dist 99, player_lane MID; then step player_dist to 101.
  - Required: coin_hit pulses exactly once; count 1→0; empty=1.
- Full and drop:
  - Fill the queue with 8 entries at dist 500.
  - A 9th push → drop pulses and count stays 8.
  - A 9th push in the same cycle as a pop → accepted, no drop, count stays 8.
- Scan ordering:
  - Stimulus: push 3 objects, then scan_start; inject a push during SCAN.
  - Required: entries stream oldest-first over 3 cycles; scan_last and scan_done on the 3rd; count=4 afterwards; no pops during the scan.
- Empty scan:
  - Stimulus: scan_start with the queue empty.
  - Required: scan_done the next cycle, scan_valid never asserted.
- Wall vs lane and turn:
  - WALL/LEFT passed with player_lane RIGHT → no wall_hit, entry still popped.
  - TURN/LEFT passed → turn_evt pulses, turn_dir=10.
- Wrap and reset:
  - Object dist 0x002 with player_dist 0xFFE → no retire.
  - Then step player_dist to 0x003 → retired.
  - Assert reset during a scan → all outputs 0 immediately, empty=1.
